// File: rtl/imem_dmem_arbiter_if.sv
// Bundles the core-side fetch/data ports and the SRAM command/response wires of the
// unified-memory arbiter. The arbiter uses the slave view, the core the master view, the macro the sram view.
interface imem_dmem_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [WIDTH-1:0]  if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [WIDTH-1:0]  dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [WIDTH-1:0]  dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport sram (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data memory, one grant per cycle.
// Data has priority, but fetch is forced through after MAX_DATA_BURST consecutive data grants.
module imem_dmem_arbiter #(
  parameter int WIDTH          = 32,
  parameter int ADDR_W         = 11,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  imem_dmem_arbiter_if.slave     bus
);

  localparam int               CNT_W     = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2
  } gnt_e;

  gnt_e             gnt;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             fetch_pending_q, fetch_pending_d;
  logic             data_pending_q, data_pending_d;

  // Grant decision depends only on requests and registered state, never on mem_rdata.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (bus.dm_req && !(bus.if_req && (burst_cnt_q == BURST_MAX))) begin
        gnt = GNT_DATA;
      end else if (bus.if_req) begin
        gnt = GNT_FETCH;
      end
    end
  end

  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (gnt)
      GNT_FETCH: begin
        bus.if_gnt   = 1'b1;
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_addr;
      end
      GNT_DATA: begin
        bus.dm_gnt    = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
      end
      default: ;
    endcase
  end

  // The counter only matters while fetch is waiting; any idle fetch cycle forgives the burst.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if ((gnt == GNT_FETCH) || !bus.if_req) begin
      burst_cnt_d = '0;
    end else if ((gnt == GNT_DATA) && (burst_cnt_q != BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_comb begin
    fetch_pending_d = (gnt == GNT_FETCH);
    data_pending_d  = (gnt == GNT_DATA) && !bus.dm_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q     <= '0;
      fetch_pending_q <= 1'b0;
      data_pending_q  <= 1'b0;
    end else begin
      burst_cnt_q     <= burst_cnt_d;
      fetch_pending_q <= fetch_pending_d;
      data_pending_q  <= data_pending_d;
    end
  end

  always_comb begin
    bus.if_rvalid = fetch_pending_q;
    bus.dm_rvalid = data_pending_q;
    bus.if_rdata  = fetch_pending_q ? bus.mem_rdata : '0;
    bus.dm_rdata  = data_pending_q  ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Randomized and directed check of the unified-memory arbiter against a transaction-level
// model: priority with bounded data bursts, a reference memory, and expected read returns.
module tb_imem_dmem_arbiter;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 11;
  localparam int MAXB   = 4;
  localparam int DEPTH  = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_dmem_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  imem_dmem_arbiter #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_DATA_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // SRAM macro stand-in: one-cycle registered read, write at the edge.
  logic [WIDTH-1:0] sram [DEPTH];
  logic [WIDTH-1:0] sram_rd_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            sram_rd_q <= sram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = sram_rd_q;

  // Reference model state
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               data_wins_while_fetch_waits;
  bit               exp_if_v, exp_dm_v;
  logic [WIDTH-1:0] exp_if_d, exp_dm_d;

  int  vec_cnt, err_cnt;
  int  if_wait_run, max_if_wait;
  bit  last_if_gnt, last_dm_gnt;
  logic [WIDTH-1:0] last_if_rdata, last_dm_rdata;
  bit  last_if_rvalid, last_dm_rvalid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit ir, input logic [ADDR_W-1:0] ia,
                      input bit dr, input bit dw, input logic [ADDR_W-1:0] da,
                      input logic [WIDTH-1:0] dd);
    bit eg_d, eg_f;
    logic [ADDR_W-1:0] ea;
    logic [WIDTH-1:0]  ewd;
    rst          = r;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dd;
    #4;
    // Data normally wins; fetch wins once it has sat through MAXB data grants.
    eg_d = !r && dr && !(ir && data_wins_while_fetch_waits >= MAXB);
    eg_f = !r && ir && !eg_d;
    ea   = eg_d ? da : (eg_f ? ia : '0);
    ewd  = eg_d ? dd : '0;
    chk("if_gnt",    bus.if_gnt,    eg_f);
    chk("dm_gnt",    bus.dm_gnt,    eg_d);
    chk("mem_en",    bus.mem_en,    eg_d | eg_f);
    chk("mem_we",    bus.mem_we,    eg_d & dw);
    chk("mem_addr",  bus.mem_addr,  ea);
    chk("mem_wdata", bus.mem_wdata, ewd);
    chk("if_rvalid", bus.if_rvalid, exp_if_v);
    chk("if_rdata",  bus.if_rdata,  exp_if_v ? exp_if_d : '0);
    chk("dm_rvalid", bus.dm_rvalid, exp_dm_v);
    chk("dm_rdata",  bus.dm_rdata,  exp_dm_v ? exp_dm_d : '0);
    $display("cyc t=%0t rst=%0b if_req=%0b dm_req=%0b we=%0b -> if_gnt=%0b dm_gnt=%0b if_rv=%0b dm_rv=%0b",
             $time, r, ir, dr, dw, bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid);
    last_if_gnt    = bus.if_gnt;
    last_dm_gnt    = bus.dm_gnt;
    last_if_rvalid = bus.if_rvalid;
    last_dm_rvalid = bus.dm_rvalid;
    last_if_rdata  = bus.if_rdata;
    last_dm_rdata  = bus.dm_rdata;
    if (!r && ir && !bus.if_gnt) if_wait_run++;
    else if_wait_run = 0;
    if (if_wait_run > max_if_wait) max_if_wait = if_wait_run;
    @(posedge clk);
    exp_if_v = eg_f;
    exp_if_d = ref_mem[ia];
    exp_dm_v = eg_d && !dw;
    exp_dm_d = ref_mem[da];
    if (eg_d && dw) ref_mem[da] = dd;
    if (r || eg_f || !ir) data_wins_while_fetch_waits = 0;
    else if (eg_d && data_wins_while_fetch_waits < MAXB) data_wins_while_fetch_waits++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [WIDTH-1:0]  v;
    logic [9:0]        pat;
    logic [ADDR_W-1:0] fa;
    bit                ir, dr, dw;
    logic [ADDR_W-1:0] ia, da;
    logic [WIDTH-1:0]  dd;

    vec_cnt = 0; err_cnt = 0; if_wait_run = 0; max_if_wait = 0;
    exp_if_v = 1'b0; exp_dm_v = 1'b0; exp_if_d = '0; exp_dm_d = '0;
    data_wins_while_fetch_waits = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      sram[i]    <= v;
      ref_mem[i]  = v;
    end
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;  bus.dm_addr = '0; bus.dm_wdata = '0;
    @(posedge clk); #1;

    // Reset holds everything quiet even with requests present
    step(1'b1, 1'b1, 11'd3, 1'b1, 1'b1, 11'd4, 32'h1234);
    idle();

    // Fetch-only stream 0..3
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 1'b1, ADDR_W'(a), 1'b0, 1'b0, '0, '0);
      chk("fo_gnt", last_if_gnt, 1'b1);
    end
    idle();
    chk("fo_last_rdata", last_if_rdata, ref_mem[3]);

    // Single collision: data read of 5 wins, fetch follows
    step(1'b0, 1'b1, 11'd9, 1'b1, 1'b0, 11'd5, '0);
    chk("coll_dgnt", last_dm_gnt, 1'b1);
    step(1'b0, 1'b1, 11'd9, 1'b0, 1'b0, '0, '0);
    chk("coll_fgnt", last_if_gnt, 1'b1);
    chk("coll_rdata", last_dm_rdata, ref_mem[5]);
    idle();

    // Starvation bound: both held for 10 cycles
    pat = '0; fa = 11'd100;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, fa, 1'b1, 1'b0, ADDR_W'(200 + i), '0);
      pat[i] = last_if_gnt;
      if (last_if_gnt) fa++;
    end
    chk("starve_pattern", pat, 10'b1000010000);
    idle();

    // Write then read of the top word
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 11'h7FF, 32'hDEADBEEF);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 11'h7FF, '0);
    chk("wr_no_rvalid", last_dm_rvalid, 1'b0);
    idle();
    chk("wr_rd_data", last_dm_rdata, 32'hDEADBEEF);

    // Reset with a fetch outstanding, then normal recovery
    step(1'b1, 1'b1, 11'd20, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 11'd20, 1'b0, 1'b0, '0, '0);
    chk("rst_no_rvalid", last_if_rvalid, 1'b0);
    chk("rst_recover_gnt", last_if_gnt, 1'b1);
    idle();
    chk("rst_recover_data", last_if_rdata, ref_mem[20]);

    for (int i = 0; i < 5; i++) idle();

    // Random traffic; requests stay stable until granted
    ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = '0; da = '0; dd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!ir && ($urandom_range(0, 9) < 7)) begin
        ir = 1'b1; ia = ADDR_W'($urandom_range(0, 31));
      end
      if (!dr && ($urandom_range(0, 9) < 7)) begin
        dr = 1'b1; dw = $urandom_range(0, 1) == 1; da = ADDR_W'($urandom_range(0, 31)); dd = $urandom;
      end
      step($urandom_range(0, 99) == 0, ir, ia, dr, dw, da, dd);
      if (last_if_gnt) ir = 1'b0;
      if (last_dm_gnt) dr = 1'b0;
    end
    idle();

    chk("max_fetch_wait_ok", max_if_wait <= MAXB, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
